// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file write port
// and tracks pending destinations. Optional load extraction/extension under WB_LOAD_EXT_EN.
module wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd_addr,
   input  logic [31:0] alu_rd_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd_addr,
   input  logic [31:0] lsu_rd_data,
   input  logic [2:0]  lsu_funct3,
   input  logic [1:0]  lsu_offset,
   input  logic        issue_en,
   input  logic [4:0]  issue_rd,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        rd_en,
   output logic [31:0] busy_mask
);

   logic [1:0]  lsu_streak;
   logic        alu_starved;
   logic        alu_grant;
   logic        lsu_grant;
   logic [31:0] lsu_wb_data;
   logic        wr_valid;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] busy_q;
   logic [31:0] busy_next;

   // The LSU normally wins contention; after three consecutive LSU wins against a waiting ALU
   // the ALU is forced through, bounding its wait to four cycles.
   assign alu_starved = alu_valid && lsu_valid && (lsu_streak == 2'd3);
   assign alu_grant   = alu_valid && (!lsu_valid || alu_starved);
   assign lsu_grant   = lsu_valid && !alu_starved;
   assign alu_ready   = alu_grant;
   assign lsu_ready   = lsu_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         lsu_streak <= 2'd0;
      end else if (!alu_valid || alu_grant) begin
         lsu_streak <= 2'd0;
      end else if (lsu_grant && (lsu_streak != 2'd3)) begin
         lsu_streak <= lsu_streak + 2'd1;
      end
   end

`ifdef WB_LOAD_EXT_EN
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
      logic [31:0] byte_sh;
      logic [31:0] half_sh;
      logic [31:0] result;
      byte_sh = word >> {offset, 3'b000};
      half_sh = word >> {offset[1], 4'b0000};
      case (funct3)
         3'b000:  result = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b001:  result = {{16{half_sh[15]}}, half_sh[15:0]};
         3'b100:  result = {24'd0, byte_sh[7:0]};
         3'b101:  result = {16'd0, half_sh[15:0]};
         default: result = word;
      endcase
      return result;
   endfunction

   assign lsu_wb_data = load_extend(lsu_rd_data, lsu_funct3, lsu_offset);
`else
   logic unused_load_sel;
   assign unused_load_sel = ^{lsu_funct3, lsu_offset};
   assign lsu_wb_data     = lsu_rd_data;
`endif

   // Writes to x0 are consumed but never reach the register file.
   always_comb begin
      wr_valid = 1'b0;
      wr_addr  = alu_rd_addr;
      wr_data  = alu_rd_data;
      if (alu_grant) begin
         wr_valid = (alu_rd_addr != 5'd0);
      end else if (lsu_grant) begin
         wr_addr  = lsu_rd_addr;
         wr_data  = lsu_wb_data;
         wr_valid = (lsu_rd_addr != 5'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en   <= 1'b0;
         rd_addr <= 5'd0;
         rd_data <= 32'd0;
      end else begin
         rd_en <= wr_valid;
         if (wr_valid) begin
            rd_addr <= wr_addr;
            rd_data <= wr_data;
         end
      end
   end

   // A new issue to the same register overrides the retiring write: the newer producer is still pending.
   always_comb begin
      busy_next = busy_q;
      if (rd_en) begin
         busy_next[rd_addr] = 1'b0;
      end
      if (issue_en && (issue_rd != 5'd0)) begin
         busy_next[issue_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 32'd0;
      end else begin
         busy_q <= busy_next;
      end
   end

   assign busy_mask = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: handshake, contention fairness, load extension,
// scoreboard timing, x0 handling and mid-stream reset.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd_addr;
   logic [31:0] alu_rd_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd_addr;
   logic [31:0] lsu_rd_data;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_offset;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_en;
   logic [31:0] busy_mask;

   int errors = 0;
   int checks = 0;

   localparam logic [7:0] ALU_TURN = 8'b1000_1000;

   logic [2:0]  ext_f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101, 3'b011};
   logic [1:0]  ext_off [8] = '{2'd0,   2'd2,   2'd2,   2'd0,   2'd0,   2'd1,   2'd2,   2'd3};
`ifdef WB_LOAD_EXT_EN
   logic [31:0] ext_exp [8] = '{32'hFFFFFF81, 32'h000000F0, 32'hFFFF80F0, 32'h00007F81,
                                32'h80F07F81, 32'h0000007F, 32'h000080F0, 32'h80F07F81};
`else
   logic [31:0] ext_exp [8] = '{32'h80F07F81, 32'h80F07F81, 32'h80F07F81, 32'h80F07F81,
                                32'h80F07F81, 32'h80F07F81, 32'h80F07F81, 32'h80F07F81};
`endif

   wb_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd_addr (alu_rd_addr),
      .alu_rd_data (alu_rd_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd_addr (lsu_rd_addr),
      .lsu_rd_data (lsu_rd_data),
      .lsu_funct3  (lsu_funct3),
      .lsu_offset  (lsu_offset),
      .issue_en    (issue_en),
      .issue_rd    (issue_rd),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_en       (rd_en),
      .busy_mask   (busy_mask)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; the extra #1 lets combinational ready settle.
   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic [2:0] f3, input logic [1:0] off,
                                input logic ie, input logic [4:0] ird);
      alu_valid   = av;
      alu_rd_addr = ard;
      alu_rd_data = ad;
      lsu_valid   = lv;
      lsu_rd_addr = lrd;
      lsu_rd_data = ld;
      lsu_funct3  = f3;
      lsu_offset  = off;
      issue_en    = ie;
      issue_rd    = ird;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b0, 5'd0);
   endtask

   task automatic contend();
      applyStimulus(1'b1, 5'd1, 32'hAAAA0001, 1'b1, 5'd2, 32'hBBBB0002, 3'b010, 2'd0, 1'b0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_rd_en",   {31'd0, rd_en}, 32'd0);
      checkOutput("reset_rd_addr", {27'd0, rd_addr}, 32'd0);
      checkOutput("reset_rd_data", rd_data, 32'd0);
      checkOutput("reset_busy",    busy_mask, 32'd0);

      // ALU alone
      applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b0, 5'd0);
      checkOutput("alu_only_alu_ready", {31'd0, alu_ready}, 32'd1);
      checkOutput("alu_only_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      tick();
      checkOutput("alu_only_rd_en",   {31'd0, rd_en}, 32'd1);
      checkOutput("alu_only_rd_addr", {27'd0, rd_addr}, 32'd5);
      checkOutput("alu_only_rd_data", rd_data, 32'h12345678);
      idle();
      tick();
      checkOutput("alu_only_pulse_end", {31'd0, rd_en}, 32'd0);

      // Sustained contention: LSU,LSU,LSU,ALU repeating
      for (int i = 0; i < 8; i++) begin
         contend();
         checkOutput($sformatf("cont%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, ALU_TURN[i]});
         checkOutput($sformatf("cont%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, ~ALU_TURN[i]});
         tick();
         checkOutput($sformatf("cont%0d_rd_en", i), {31'd0, rd_en}, 32'd1);
         checkOutput($sformatf("cont%0d_rd_addr", i), {27'd0, rd_addr},
                     ALU_TURN[i] ? 32'd1 : 32'd2);
         checkOutput($sformatf("cont%0d_rd_data", i), rd_data,
                     ALU_TURN[i] ? 32'hAAAA0001 : 32'hBBBB0002);
      end
      idle();
      tick();

      // Load extraction / extension
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h80F07F81, ext_f3[i], ext_off[i], 1'b0, 5'd0);
         checkOutput($sformatf("ext%0d_lsu_ready", i), {31'd0, lsu_ready}, 32'd1);
         tick();
         checkOutput($sformatf("ext%0d_rd_data", i), rd_data, ext_exp[i]);
      end
      idle();
      tick();

      // Scoreboard: issue x7 at cycle 0, ALU write of x7 accepted at cycle 3
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b1, 5'd7);
      tick();
      checkOutput("sb_c1_busy", busy_mask, 32'h00000080);
      idle();
      tick();
      checkOutput("sb_c2_busy", busy_mask, 32'h00000080);
      tick();
      checkOutput("sb_c3_busy", busy_mask, 32'h00000080);
      applyStimulus(1'b1, 5'd7, 32'hCAFE0007, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b0, 5'd0);
      tick();
      checkOutput("sb_c4_rd_en", {31'd0, rd_en}, 32'd1);
      checkOutput("sb_c4_busy", busy_mask, 32'h00000080);
      idle();
      tick();
      checkOutput("sb_c5_busy", busy_mask, 32'h00000000);

      // Scoreboard: re-issue x7 in the write cycle keeps the bit set
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b1, 5'd7);
      tick();
      applyStimulus(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b0, 5'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b1, 5'd7);
      checkOutput("sb_setwin_rd_en", {31'd0, rd_en}, 32'd1);
      tick();
      checkOutput("sb_setwin_busy", busy_mask, 32'h00000080);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h00000078, 3'b010, 2'd0, 1'b0, 5'd0);
      tick();
      idle();
      tick();
      checkOutput("sb_lsu_clear_busy", busy_mask, 32'h00000000);

      // x0 write and x0 issue
      applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b1, 5'd0);
      checkOutput("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      checkOutput("x0_rd_en", {31'd0, rd_en}, 32'd0);
      checkOutput("x0_busy",  busy_mask, 32'h00000000);
      idle();
      tick();

      // Reset in the middle of contention (streak at 2, x9 pending)
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b010, 2'd0, 1'b1, 5'd9);
      tick();
      checkOutput("rst_pre_busy", busy_mask, 32'h00000200);
      contend();
      tick();
      tick();
      rst = 1'b1;
      contend();
      tick();
      checkOutput("rst_mid_rd_en", {31'd0, rd_en}, 32'd0);
      checkOutput("rst_mid_busy",  busy_mask, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         contend();
         checkOutput($sformatf("rst_post%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, ALU_TURN[i]});
         checkOutput($sformatf("rst_post%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, ~ALU_TURN[i]});
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
